// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and fills the IF/ID pipeline register. Handles stalls, squashes on redirect,
// and remembers a redirect that arrives while stalled so it can be applied later.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] BTA,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus_4_q, pc_plus_4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic [31:0] pc_plus_4;
  logic        new_redir;
  logic [31:0] sel_target;
  logic        redir_valid;
  logic [31:0] redir_target;

  assign pc_plus_4 = pc_q + 32'd4;
  assign new_redir = jr | jump | branch_taken;

  // Pick this cycle's redirect target (jr > jump > branch), word-aligned.
  always_comb begin
    sel_target = BTA;
    if (jr) begin
      sel_target = jr_target;
    end else if (jump) begin
      // Region bits come from the jump's own PC+4, which sits in IF/ID.
      sel_target = {pc_plus_4_q[31:28], jump_index, 2'b00};
    end else begin
      sel_target = BTA;
    end
    sel_target[1:0] = 2'b00;
  end

  // A fresh redirect beats one deferred from an earlier stall.
  always_comb begin
    redir_valid  = new_redir | pending_valid_q;
    redir_target = new_redir ? sel_target : pending_target_q;
  end

  // Next-state for PC, IF/ID, fetch counter and deferred redirect.
  always_comb begin
    pc_d             = pc_q;
    instr_d          = instr_q;
    pc_plus_4_d      = pc_plus_4_q;
    valid_d          = valid_q;
    count_d          = count_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;

    if (stall) begin
      // Hold everything; latch the latest redirect so it is not lost.
      if (new_redir) begin
        pending_valid_d  = 1'b1;
        pending_target_d = sel_target;
      end
    end else if (redir_valid) begin
      // Discard the instruction at the old PC and insert a bubble.
      pc_d            = redir_target;
      instr_d         = 32'h0000_0000;
      pc_plus_4_d     = 32'h0000_0000;
      valid_d         = 1'b0;
      pending_valid_d = 1'b0;
    end else begin
      pc_d        = pc_plus_4;
      instr_d     = imem_data;
      pc_plus_4_d = pc_plus_4;
      valid_d     = 1'b1;
      count_d     = count_q + 32'd1;
    end
  end

  // State registers with synchronous reset overriding stall and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      instr_q          <= 32'h0000_0000;
      pc_plus_4_q      <= 32'h0000_0000;
      valid_q          <= 1'b0;
      count_q          <= 32'h0000_0000;
      pending_valid_q  <= 1'b0;
      pending_target_q <= 32'h0000_0000;
    end else begin
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      pc_plus_4_q      <= pc_plus_4_d;
      valid_q          <= valid_d;
      count_q          <= count_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign if_id_instr     = instr_q;
  assign if_id_pc_plus_4 = pc_plus_4_q;
  assign if_id_valid     = valid_q;
  assign fetch_count     = count_q;

endmodule
